// File: rtl/z80fi_insn_capture_if.sv
// Z80 formal-interface capture bus: core fetch/retire
// signals in, retired-instruction packet out.
interface z80fi_insn_capture_if;
  logic        fetch_valid;
  logic [7:0]  fetch_byte;
  logic        insn_start;
  logic        insn_done;
  logic [79:0] core_regs;
  logic        z80fi_valid;
  logic [31:0] z80fi_insn;
  logic [2:0]  z80fi_insn_len;
  logic [79:0] z80fi_regs_in;
  logic [79:0] z80fi_regs_out;
  logic        z80fi_err;

  modport master (
    output fetch_valid, fetch_byte,
    output insn_start, insn_done, core_regs,
    input  z80fi_valid, z80fi_insn,
    input  z80fi_insn_len, z80fi_regs_in,
    input  z80fi_regs_out, z80fi_err
  );

  modport slave (
    input  fetch_valid, fetch_byte,
    input  insn_start, insn_done, core_regs,
    output z80fi_valid, z80fi_insn,
    output z80fi_insn_len, z80fi_regs_in,
    output z80fi_regs_out, z80fi_err
  );
endinterface

// File: rtl/z80fi_insn_capture.sv
// Collects the bytes of each Z80 instruction and emits
// one retirement packet with pre/post register state.
module z80fi_insn_capture #(
  parameter int MAX_LEN = 4
) (
  input logic clk,
  input logic reset,
  z80fi_insn_capture_if.slave bus
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
  localparam logic [2:0] MAX     = 3'(MAX_LEN);

  logic [0:0]  state;
  logic [31:0] buf_insn;
  logic [2:0]  buf_len;
  logic [79:0] buf_regs_in;

  logic        valid_q;
  logic [31:0] insn_q;
  logic [2:0]  len_q;
  logic [79:0] rin_q;
  logic [79:0] rout_q;
  logic        err_q;

  logic        start_ok;
  logic        append;
  logic        room;
  logic        overflow;
  logic [31:0] app_insn;
  logic [2:0]  app_len;

  // Buffer as it would look with this cycle's byte added
  always_comb begin
    start_ok = bus.insn_start & bus.fetch_valid;
    append   = bus.fetch_valid & ~bus.insn_start;
    room     = buf_len < MAX;
    overflow = append & ~room;
    app_insn = buf_insn;
    app_len  = buf_len;
    if (append && room) begin
      for (int i = 0; i < 4; i++) begin
        if (buf_len == 3'(i)) begin
          app_insn[8*i +: 8] = bus.fetch_byte;
        end
      end
      app_len = buf_len + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      buf_insn    <= '0;
      buf_len     <= '0;
      buf_regs_in <= '0;
      valid_q     <= 1'b0;
      insn_q      <= '0;
      len_q       <= '0;
      rin_q       <= '0;
      rout_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (bus.insn_start && !bus.fetch_valid) begin
        err_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.insn_done) begin
            err_q <= 1'b1;
          end
          if (start_ok) begin
            buf_regs_in <= bus.core_regs;
            buf_insn    <= {24'h0, bus.fetch_byte};
            buf_len     <= 3'd1;
            state       <= COLLECT;
          end
        end
        COLLECT: begin
          if (overflow) begin
            err_q <= 1'b1;
          end
          if (bus.insn_done) begin
            valid_q <= 1'b1;
            insn_q  <= app_insn;
            len_q   <= app_len;
            rin_q   <= buf_regs_in;
            rout_q  <= bus.core_regs;
          end else if (start_ok) begin
            err_q <= 1'b1;
          end
          // A new start always wins the buffer
          if (start_ok) begin
            buf_regs_in <= bus.core_regs;
            buf_insn    <= {24'h0, bus.fetch_byte};
            buf_len     <= 3'd1;
          end else if (bus.insn_done) begin
            state <= IDLE;
          end else begin
            buf_insn <= app_insn;
            buf_len  <= app_len;
          end
        end
      endcase
    end
  end

  assign bus.z80fi_valid    = valid_q;
  assign bus.z80fi_insn     = insn_q;
  assign bus.z80fi_insn_len = len_q;
  assign bus.z80fi_regs_in  = rin_q;
  assign bus.z80fi_regs_out = rout_q;
  assign bus.z80fi_err      = err_q;

endmodule

// File: doc/z80fi_insn_capture.md
Z80FI_INSN_CAPTURE -- requirements
Module: z80fi_insn_capture

Interface
REQ-001 SHALL have parameter MAX_LEN, default 4, meaning the maximum number of instruction bytes captured (range 1..4).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port fetch_valid, input, 1 bit: the core fetched an instruction byte this cycle.
REQ-005 SHALL have port fetch_byte, input, 8 bits: the fetched byte; meaningful only when fetch_valid=1.
REQ-006 SHALL have port insn_start, input, 1 bit: the byte fetched this cycle is the first byte of a new instruction.
REQ-007 SHALL have port insn_done, input, 1 bit: the current instruction retires this cycle.
REQ-008 SHALL have port core_regs, input, 80 bits: live core state packed as {ip[15:0], a, f, b, c, d, e, h, l}, with l at [7:0].
REQ-009 SHALL have port z80fi_valid, output, 1 bit: one-cycle retirement pulse.
REQ-010 SHALL have port z80fi_insn, output, 32 bits: captured bytes, byte0 at [7:0], byte1 at [15:8], and so on; unused bytes are 0.
REQ-011 SHALL have port z80fi_insn_len, output, 3 bits: number of captured bytes (1..MAX_LEN).
REQ-012 SHALL have port z80fi_regs_in, output, 80 bits: core_regs sampled at insn_start, using the same packing as core_regs.
REQ-013 SHALL have port z80fi_regs_out, output, 80 bits: core_regs sampled at insn_done, using the same packing as core_regs.
REQ-014 SHALL have port z80fi_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-015 SHALL implement a capture FSM with states IDLE and COLLECT, plus an independent output stage.
REQ-016 IDLE: when insn_start=1 and fetch_valid=1, SHALL set buf_regs_in=core_regs, buf_insn={24'h0, fetch_byte}, buf_len=1, and go to COLLECT.
REQ-017 COLLECT, fetch_valid=1, insn_start=0, buf_len<MAX_LEN: SHALL write fetch_byte into buf_insn[8*buf_len +: 8] and increment buf_len.
REQ-018 COLLECT, fetch_valid=1, insn_start=0, buf_len==MAX_LEN: SHALL drop the byte, leave buf_len unchanged, and set z80fi_err.
REQ-019 COLLECT, insn_done=1: SHALL copy the buffer to the output registers; z80fi_insn, z80fi_insn_len, z80fi_regs_in, and z80fi_regs_out (=core_regs this cycle) update at the edge; z80fi_valid=1 for exactly the next cycle (latency 1).
REQ-020 A byte with fetch_valid=1 in the same cycle as insn_done (insn_start=0) SHALL be included in the retired packet, subject to REQ-018.
REQ-021 insn_done together with insn_start+fetch_valid in COLLECT SHALL retire the old instruction per REQ-019 and restart the buffer per REQ-016 in the same edge; the FSM stays in COLLECT; no error.
REQ-022 insn_done alone in COLLECT SHALL return the FSM to IDLE.
REQ-023 insn_start+fetch_valid in COLLECT without insn_done SHALL abandon the buffer (no z80fi_valid), restart it per REQ-016, and set z80fi_err.
REQ-024 insn_start=1 with fetch_valid=0, in any state, SHALL be ignored and SHALL set z80fi_err.
REQ-025 insn_done=1 in IDLE SHALL be ignored (no z80fi_valid) and SHALL set z80fi_err.
REQ-026 fetch_valid=1 in IDLE without insn_start SHALL be ignored, with no error (refresh and halt fetches are not captured).
REQ-027 z80fi outputs SHALL hold their last values while z80fi_valid=0; z80fi_err is cleared only by reset.
REQ-028 Back-to-back retirements on consecutive cycles SHALL each produce a one-cycle z80fi_valid pulse, giving z80fi_valid high on consecutive cycles.

Reset
REQ-029 reset=1 SHALL immediately, without waiting for a clock edge, force: FSM=IDLE, z80fi_valid=0, z80fi_insn=0, z80fi_insn_len=0, z80fi_regs_in=0, z80fi_regs_out=0, z80fi_err=0, and the internal buffer to 0.
REQ-030 Reset asserted mid-COLLECT SHALL discard the partial instruction; no z80fi_valid is produced for it after release.

Verification
REQ-031 Single byte: start+fetch 8'h3C (core ip=16'h0100, a=8'h7F), then done with ip=16'h0101, a=8'h80 -> next cycle z80fi_valid=1, z80fi_insn=32'h0000003C, len=1, regs_in.ip=16'h0100, regs_out.a=8'h80.
REQ-032 Four bytes DD 21 34 12, with done coinciding with the last fetch -> z80fi_insn=32'h123421DD, len=4, err=0.
REQ-033 Overflow: five fetches 01..05 then done -> z80fi_insn=32'h04030201, len=4, err=1.
REQ-034 Back-to-back: 8'h04 retires in the same cycle that start+fetch 8'h05 occurs, and 8'h05 retires the next cycle -> z80fi_valid high two consecutive cycles with z80fi_insn 32'h04 then 32'h05; err=0.
REQ-035 Protocol errors: done in IDLE -> no z80fi_valid, err=1; in a second run, start+fetch 8'h06 then start+fetch 8'h07 without done -> no valid for 8'h06, err=1, and a later done reports z80fi_insn=32'h07.
REQ-036 Reset after two bytes of CB 27, then a fresh single-byte 8'h00 instruction -> all outputs 0 during reset, and exactly one valid after release, with z80fi_insn=32'h0, len=1.
